// File: rtl/ofifo_pkg.sv
// Shared defaults and sizing helpers for the output FIFO between the MAC array and the readout path.
package ofifo_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 64;

    // Occupancy counter width: needs one extra bit to represent "depth" itself.
    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_if.sv
// Row-level bus between the MAC array / readout logic (master) and the output FIFO (slave).
interface ofifo_if
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW
);

    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, o_overflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, o_overflow
    );

endinterface

// File: rtl/ofifo_fifo_lane.sv
// Single-column circular buffer; read data is presented combinationally at the read pointer.
module fifo_lane
    import ofifo_pkg::*;
#(
    parameter int width = PSUM_BW,
    parameter int depth = DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic [width-1:0] din_i,
    output logic [width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(depth);
    localparam int PW = ptr_w(depth);
    localparam logic [PW-1:0] FULL_CNT = PW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             wr_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    // A same-cycle pop frees the slot, so a full lane can still take a write.
    assign wr_ok   = wr_i && (!full_o || rd_i);
    assign drop_o  = wr_i && full_o && !rd_i;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_i})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: one independent lane per array column, drained a full row at a time.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    ofifo_if.slave   bus
);

    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_empty;
    logic [col-1:0]         lane_drop;
    logic [psum_bw*col-1:0] row_data;
    logic [psum_bw*col-1:0] out_q;
    logic                   overflow_q;
    logic                   rd_accept;

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_lane
            fifo_lane #(
                .width (psum_bw),
                .depth (depth)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .wr_i    (bus.wr[gi]),
                .rd_i    (rd_accept),
                .din_i   (bus.in[psum_bw*gi +: psum_bw]),
                .dout_o  (row_data[psum_bw*gi +: psum_bw]),
                .full_o  (lane_full[gi]),
                .empty_o (lane_empty[gi]),
                .drop_o  (lane_drop[gi])
            );
        end
    endgenerate

    // Flags depend only on registered lane counts, never on this cycle's wr/rd.
    assign bus.o_valid    = ~|lane_empty;
    assign bus.o_full     = |lane_full;
    assign bus.o_ready    = ~bus.o_full;
    assign bus.o_overflow = overflow_q;
    assign bus.out        = out_q;
    assign rd_accept      = bus.rd && bus.o_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (rd_accept) out_q <= row_data;
            if (|lane_drop) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo: skewed fill, full/overflow boundary, concurrent access, wrap and async reset.
module tb_ofifo;

    localparam int COLS = 8;
    localparam int BW   = 16;
    localparam int DEP  = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ofifo_if #(.col(COLS), .psum_bw(BW)) bus ();

    ofifo #(.col(COLS), .psum_bw(BW), .depth(DEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] rep(input int v);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) r[BW*c +: BW] = 16'(v);
        return r;
    endfunction

    function automatic logic [127:0] ramp(input int base, input int step);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) r[BW*c +: BW] = 16'(base + c * step);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input logic [7:0] w, input logic r, input logic [127:0] d);
        bus.wr = w;
        bus.rd = r;
        bus.in = d;
        @(posedge clk);
        #1;
        bus.wr = '0;
        bus.rd = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_row;
        n_checks = 0;
        n_fail   = 0;
        bus.wr   = '0;
        bus.rd   = 1'b0;
        bus.in   = '0;
        reset    = 1'b1;

        // Reset state
        #13;
        check("rst_valid", 128'(bus.o_valid), 128'(0));
        check("rst_full", 128'(bus.o_full), 128'(0));
        check("rst_ready", 128'(bus.o_ready), 128'(1));
        check("rst_ovf", 128'(bus.o_overflow), 128'(0));
        check("rst_out", bus.out, '0);
        reset = 1'b0;

        // Skewed fill: lane c written on cycle c
        for (int c = 0; c < COLS; c++) begin
            cyc(8'(1 << c), 1'b0, ramp(16'h0100, 1));
            check("skew_valid", 128'(bus.o_valid), 128'(c == COLS - 1));
        end
        cyc(8'h00, 1'b1, '0);
        check("skew_out", bus.out, ramp(16'h0100, 1));
        check("skew_valid0", 128'(bus.o_valid), 128'(0));

        // Read while empty is ignored
        cyc(8'h00, 1'b1, '0);
        check("empty_out", bus.out, ramp(16'h0100, 1));
        check("empty_valid", 128'(bus.o_valid), 128'(0));

        // Full boundary and overflow
        for (int i = 0; i < DEP; i++) begin
            cyc(8'hFF, 1'b0, rep(i));
            check("fill_full", 128'(bus.o_full), 128'(i == DEP - 1));
        end
        check("full_ready", 128'(bus.o_ready), 128'(0));
        check("full_ovf", 128'(bus.o_overflow), 128'(0));
        cyc(8'hFF, 1'b0, rep(99));
        check("ovf_set", 128'(bus.o_overflow), 128'(1));
        check("ovf_full", 128'(bus.o_full), 128'(1));
        for (int i = 0; i < DEP; i++) begin
            cyc(8'h00, 1'b1, '0);
            check("drain_out", bus.out, rep(i));
            if (i == 0) check("drain_full", 128'(bus.o_full), 128'(0));
        end
        check("drain_valid", 128'(bus.o_valid), 128'(0));
        check("ovf_sticky", 128'(bus.o_overflow), 128'(1));

        // Concurrent write and read while full
        #2;
        reset = 1'b1;
        #1;
        check("rst2_ovf", 128'(bus.o_overflow), 128'(0));
        reset = 1'b0;
        for (int i = 0; i < DEP; i++) cyc(8'hFF, 1'b0, rep(16'h0200 + i));
        check("conc_pre_full", 128'(bus.o_full), 128'(1));
        cyc(8'hFF, 1'b1, rep(16'h02FF));
        check("conc_out", bus.out, rep(16'h0200));
        check("conc_full", 128'(bus.o_full), 128'(1));
        check("conc_ovf", 128'(bus.o_overflow), 128'(0));
        for (int i = 1; i <= DEP; i++) begin
            cyc(8'h00, 1'b1, '0);
            exp_row = (i < DEP) ? rep(16'h0200 + i) : rep(16'h02FF);
            check("conc_drain", bus.out, exp_row);
        end
        check("conc_valid", 128'(bus.o_valid), 128'(0));

        // Wrap-around: interleaved write/read pairs
        for (int k = 0; k < 200; k++) begin
            exp_row = ramp(k * 8, 1);
            cyc(8'hFF, 1'b0, exp_row);
            check("wrap_valid", 128'(bus.o_valid), 128'(1));
            cyc(8'h00, 1'b1, '0);
            check("wrap_out", bus.out, exp_row);
        end

        // Asynchronous reset with entries buffered
        for (int i = 0; i < 10; i++) cyc(8'hFF, 1'b0, rep(16'h0300 + i));
        check("ar_valid_pre", 128'(bus.o_valid), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 128'(bus.o_valid), 128'(0));
        check("ar_out", bus.out, '0);
        check("ar_ready", 128'(bus.o_ready), 128'(1));
        #1;
        reset = 1'b0;
        cyc(8'hFF, 1'b0, ramp(16'h0A00, 3));
        check("ar_fresh_val", 128'(bus.o_valid), 128'(1));
        cyc(8'h00, 1'b1, '0);
        check("ar_fresh_out", bus.out, ramp(16'h0A00, 3));
        check("ar_empty", 128'(bus.o_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
